// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding imem
// requests and fills the IF/ID register consumed by stage_one. A one-entry
// hold buffer catches a response that lands while stage_one is stalled.
module fetch_stage #(
  parameter int                  PC_W      = 16,
  parameter int                  INSTR_W   = 16,
  parameter logic [PC_W-1:0]     RESET_PC  = '0,
  parameter logic [INSTR_W-1:0]  NOP_INSTR = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               halt_sys,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic               out_valid,
  output logic               halted
);

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN, HALTED} state_t;

  state_t             state;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] hold_instr;
  logic [PC_W-1:0]    hold_pc;
  logic               halt_pend;

  // Redirect target is always halfword aligned; PC wraps modulo 2^PC_W.
  logic [PC_W-1:0] br_pc;
  logic [PC_W-1:0] pc_inc;
  assign br_pc  = {branch_target[PC_W-1:1], 1'b0};
  assign pc_inc = pc + PC_W'(2);

  // Fetch FSM with registered request, IF/ID and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      imem_req   <= 1'b0;
      imem_addr  <= RESET_PC;
      out_instr  <= NOP_INSTR;
      out_pc     <= '0;
      out_valid  <= 1'b0;
      halted     <= 1'b0;
      hold_instr <= NOP_INSTR;
      hold_pc    <= '0;
      halt_pend  <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (halt_sys) begin
            out_valid <= 1'b0;
            out_instr <= NOP_INSTR;
            // An in-flight request must complete before we can stop.
            if (imem_req && !imem_ack) begin
              halt_pend <= 1'b1;
              state     <= DRAIN;
            end else begin
              imem_req <= 1'b0;
              halted   <= 1'b1;
              state    <= HALTED;
            end
          end else if (branch_taken) begin
            out_valid <= 1'b0;
            out_instr <= NOP_INSTR;
            pc        <= br_pc;
            if (imem_req && !imem_ack) begin
              state <= DRAIN;
            end else begin
              // Any same-cycle response is for the wrong path: drop it.
              imem_req  <= 1'b1;
              imem_addr <= br_pc;
            end
          end else if (imem_req && imem_ack) begin
            if (!stall) begin
              out_instr <= imem_rdata;
              out_pc    <= pc;
              out_valid <= 1'b1;
              pc        <= pc_inc;
              imem_addr <= pc_inc;
            end else begin
              hold_instr <= imem_rdata;
              hold_pc    <= pc;
              imem_req   <= 1'b0;
              state      <= HOLD;
            end
          end else if (imem_req) begin
            if (!stall) begin
              out_valid <= 1'b0;
              out_instr <= NOP_INSTR;
            end
          end else begin
            // Idle after reset: launch the first request.
            imem_req  <= 1'b1;
            imem_addr <= pc;
            if (!stall) begin
              out_valid <= 1'b0;
              out_instr <= NOP_INSTR;
            end
          end
        end

        HOLD: begin
          if (halt_sys) begin
            out_valid <= 1'b0;
            out_instr <= NOP_INSTR;
            halted    <= 1'b1;
            state     <= HALTED;
          end else if (branch_taken) begin
            out_valid <= 1'b0;
            out_instr <= NOP_INSTR;
            pc        <= br_pc;
            imem_req  <= 1'b1;
            imem_addr <= br_pc;
            state     <= FETCH;
          end else if (!stall) begin
            out_instr <= hold_instr;
            out_pc    <= hold_pc;
            out_valid <= 1'b1;
            pc        <= pc_inc;
            imem_req  <= 1'b1;
            imem_addr <= pc_inc;
            state     <= FETCH;
          end
        end

        DRAIN: begin
          if (halt_sys) begin
            halt_pend <= 1'b1;
          end else if (branch_taken) begin
            pc <= br_pc;
          end
          if (halt_sys || branch_taken) begin
            out_valid <= 1'b0;
            out_instr <= NOP_INSTR;
          end
          // Wait out the uncancellable request, then discard its data.
          if (imem_ack) begin
            if (halt_sys || halt_pend) begin
              imem_req <= 1'b0;
              halted   <= 1'b1;
              state    <= HALTED;
            end else begin
              imem_req  <= 1'b1;
              imem_addr <= branch_taken ? br_pc : pc;
              state     <= FETCH;
            end
          end
        end

        HALTED: begin
          imem_req  <= 1'b0;
          out_valid <= 1'b0;
          out_instr <= NOP_INSTR;
          halted    <= 1'b1;
        end

        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, stall hold buffer,
// redirect drain, halt, PC wrap and mid-request reset.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        halt_sys = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_target = '0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic        out_valid;
  logic        halted;

  // second instance for PC wrap from a high reset vector
  logic        rst2 = 1'b1;
  logic        req2;
  logic [15:0] addr2;
  logic [15:0] instr2;
  logic [15:0] pc2;
  logic        valid2;
  logic        halted2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .halt_sys(halt_sys),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .out_instr(out_instr), .out_pc(out_pc),
    .out_valid(out_valid), .halted(halted)
  );

  fetch_stage #(.RESET_PC(16'hFFFC)) dut2 (
    .clk(clk), .rst(rst2), .stall(1'b0), .halt_sys(1'b0),
    .branch_taken(1'b0), .branch_target(16'h0000),
    .imem_req(req2), .imem_addr(addr2), .imem_ack(1'b1),
    .imem_rdata(16'h7000), .out_instr(instr2), .out_pc(pc2),
    .out_valid(valid2), .halted(halted2)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    #1;
    check("rst_req",    16'(imem_req), 16'd0);
    check("rst_valid",  16'(out_valid), 16'd0);
    check("rst_instr",  out_instr, 16'h0000);
    check("rst_pc",     out_pc, 16'h0000);
    check("rst_halted", 16'(halted), 16'd0);
    tick();
    rst = 1'b0;
    tick();
    check("first_req",  16'(imem_req), 16'd1);
    check("first_addr", imem_addr, 16'h0000);

    // zero-wait memory, no stall
    imem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      imem_rdata = 16'hA000 + 16'(2 * i);
      tick();
      check("seq_pc",    out_pc, 16'(2 * i));
      check("seq_instr", out_instr, 16'hA000 + 16'(2 * i));
      check("seq_valid", 16'(out_valid), 16'd1);
      check("seq_addr",  imem_addr, 16'(2 * i + 2));
    end

    // ack under stall: capture into hold buffer, freeze IF/ID for 3 cycles
    stall = 1'b1;
    imem_rdata = 16'hB008;
    tick();
    check("stall_req",   16'(imem_req), 16'd0);
    check("stall_pc",    out_pc, 16'h0006);
    check("stall_instr", out_instr, 16'hA006);
    check("stall_valid", 16'(out_valid), 16'd1);
    imem_rdata = 16'hDEAD;  // acks while no request is out must be ignored
    for (int i = 0; i < 2; i++) begin
      tick();
      check("hold_req",   16'(imem_req), 16'd0);
      check("hold_instr", out_instr, 16'hA006);
    end
    stall = 1'b0;
    imem_ack = 1'b0;
    tick();
    check("rel_instr", out_instr, 16'hB008);
    check("rel_pc",    out_pc, 16'h0008);
    check("rel_valid", 16'(out_valid), 16'd1);
    check("rel_req",   16'(imem_req), 16'd1);
    check("rel_addr",  imem_addr, 16'h000A);

    // no ack: bubble
    tick();
    check("bub_valid", 16'(out_valid), 16'd0);
    check("bub_instr", out_instr, 16'h0000);
    check("bub_addr",  imem_addr, 16'h000A);

    // run up to a pending request at 0x0010
    imem_ack = 1'b1;
    imem_rdata = 16'h1111;
    tick(); tick(); tick();
    check("pre_br_pc",   out_pc, 16'h000E);
    check("pre_br_addr", imem_addr, 16'h0010);

    // redirect to 0x0041 while 0x0010 is outstanding
    imem_ack = 1'b0;
    branch_taken = 1'b1;
    branch_target = 16'h0041;
    tick();
    branch_taken = 1'b0;
    check("br_flush_valid", 16'(out_valid), 16'd0);
    check("br_flush_instr", out_instr, 16'h0000);
    check("br_drain_addr",  imem_addr, 16'h0010);
    imem_ack = 1'b1;
    imem_rdata = 16'hBAD0;
    tick();
    check("br_discard_valid", 16'(out_valid), 16'd0);
    check("br_new_addr",      imem_addr, 16'h0040);
    imem_rdata = 16'hC040;
    tick();
    check("br_out_pc",    out_pc, 16'h0040);
    check("br_out_instr", out_instr, 16'hC040);
    check("br_out_valid", 16'(out_valid), 16'd1);

    // halt together with branch while a request is pending
    imem_ack = 1'b0;
    halt_sys = 1'b1;
    branch_taken = 1'b1;
    branch_target = 16'h0080;
    tick();
    halt_sys = 1'b0;
    branch_taken = 1'b0;
    check("halt_flush",  16'(out_valid), 16'd0);
    check("halt_wait",   16'(halted), 16'd0);
    check("halt_addr",   imem_addr, 16'h0042);
    tick();
    check("halt_wait2",  16'(halted), 16'd0);
    check("halt_req2",   16'(imem_req), 16'd1);
    imem_ack = 1'b1;
    tick();
    check("halted",      16'(halted), 16'd1);
    check("halted_req",  16'(imem_req), 16'd0);
    stall = 1'b1;
    branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("halted_stay", 16'(halted), 16'd1);
      check("halted_noreq", 16'(imem_req), 16'd0);
      check("halted_nov", 16'(out_valid), 16'd0);
    end
    stall = 1'b0;
    branch_taken = 1'b0;
    imem_ack = 1'b0;

    // reset exits halt, then reset again with a request pending
    rst = 1'b1;
    #1;
    check("rst2_halted", 16'(halted), 16'd0);
    tick();
    rst = 1'b0;
    tick();
    check("rst2_req",  16'(imem_req), 16'd1);
    check("rst2_addr", imem_addr, 16'h0000);
    tick();  // request still pending
    rst = 1'b1;
    #1;
    check("midrst_req",   16'(imem_req), 16'd0);
    check("midrst_valid", 16'(out_valid), 16'd0);
    check("midrst_pc",    out_pc, 16'h0000);
    check("midrst_instr", out_instr, 16'h0000);
    rst = 1'b0;
    imem_ack = 1'b1;          // stale ack for the dropped request
    imem_rdata = 16'hBEEF;
    tick();
    check("stale_valid", 16'(out_valid), 16'd0);
    check("stale_req",   16'(imem_req), 16'd1);
    check("stale_addr",  imem_addr, 16'h0000);
    imem_rdata = 16'h1234;
    tick();
    check("post_rst_pc",    out_pc, 16'h0000);
    check("post_rst_instr", out_instr, 16'h1234);
    check("post_rst_valid", 16'(out_valid), 16'd1);
    imem_ack = 1'b0;

    // PC wrap from RESET_PC=FFFC with ack every cycle
    rst2 = 1'b0;
    tick();
    check("wrap_addr0", addr2, 16'hFFFC);
    check("wrap_req0",  16'(req2), 16'd1);
    tick();
    check("wrap_pc0", pc2, 16'hFFFC);
    check("wrap_v0",  16'(valid2), 16'd1);
    tick();
    check("wrap_pc1", pc2, 16'hFFFE);
    tick();
    check("wrap_pc2",   pc2, 16'h0000);
    check("wrap_addr2", addr2, 16'h0002);
    check("wrap_halt",  16'(halted2), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
